// File: rtl/alu_flow_unit.sv
// alu_flow_unit: program-flow stage behind the 20-bit ALU logic/shift unit.
// It holds the {C,S,Z} status register and resolves conditional jumps against it.
// It sends registered branch decisions to fetch.
// It parks the core in TRAP on an explicit trap or an illegal opcode until trap_clr.
module alu_flow_unit #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic [DATA_W-1:0] operand,
  input  logic              trap_clr,
  output logic [2:0]        status,
  output logic              br_valid,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic              trap,
  output logic              trap_cause,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_FLAGS = 4'd1,
    OP_JMP   = 4'd2,
    OP_JZ    = 4'd3,
    OP_JS    = 4'd4,
    OP_JZS   = 4'd5,
    OP_LSR   = 4'd6,
    OP_XSR   = 4'd7,
    OP_TRAP  = 4'd8
  } op_e;

  state_e state;
  logic   accept;
  logic   cond;
  logic   is_jump;
  logic   flag_z;
  logic   flag_s;

  // Only the sign bit of the ALU result feeds the status register.
  logic unused_result_bits;
  assign unused_result_bits = ^alu_result[DATA_W-2:0];

  assign flag_z   = status[0];
  assign flag_s   = status[1];

  // Handshake and trap indication come straight from the state register.
  assign in_ready = (state == ST_RUN);
  assign trap     = (state == ST_TRAP);
  assign accept   = in_valid && in_ready;

  // Resolve the jump condition against the status held before this op.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path leaves it unassigned, which would infer a latch.
    cond    = 1'b0;
    is_jump = 1'b0;
    case (op)
      OP_JMP: begin cond = 1'b1;            is_jump = 1'b1; end
      OP_JZ:  begin cond = flag_z;          is_jump = 1'b1; end
      OP_JS:  begin cond = flag_s;          is_jump = 1'b1; end
      OP_JZS: begin cond = flag_z | flag_s; is_jump = 1'b1; end
      default: ;
    endcase
  end

  // Run/trap FSM together with all the architectural state it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values and process order cannot create races.
    if (!rst_n) begin
      state      <= ST_RUN;
      status     <= 3'b000;
      br_valid   <= 1'b0;
      br_taken   <= 1'b0;
      br_target  <= '0;
      trap_cause <= 1'b0;
      retired    <= '0;
    end else begin
      br_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (op < OP_TRAP) begin
              retired <= retired + CNT_W'(1);
            end
            if (is_jump) begin
              br_valid  <= 1'b1;
              br_taken  <= cond;
              br_target <= operand[ADDR_W-1:0];
            end
            case (op)
              OP_FLAGS: status <= {alu_carry, alu_result[DATA_W-1], alu_zero};
              OP_LSR:   status <= operand[2:0];
              OP_XSR:   status <= status ^ operand[2:0];
              OP_NOP, OP_JMP, OP_JZ, OP_JS, OP_JZS: ;
              OP_TRAP: begin
                state      <= ST_TRAP;
                trap_cause <= 1'b0;
              end
              default: begin
                state      <= ST_TRAP;
                trap_cause <= 1'b1;
              end
            endcase
          end
        end
        ST_TRAP: begin
          if (trap_clr) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flow_unit.sv
// Directed bench for alu_flow_unit: status updates, jumps, trap entry/exit,
// async reset during trap and retired-counter wrap.
module tb_alu_flow_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [19:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic [19:0] operand;
  logic        trap_clr;
  logic [2:0]  status;
  logic        br_valid;
  logic        br_taken;
  logic [19:0] br_target;
  logic        trap;
  logic        trap_cause;
  logic [15:0] retired;

  int pass_cnt = 0;
  int total    = 0;
  logic [15:0] exp_ret = '0;

  alu_flow_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .operand(operand), .trap_clr(trap_clr), .status(status), .br_valid(br_valid),
    .br_taken(br_taken), .br_target(br_target), .trap(trap), .trap_cause(trap_cause),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // One accepted op: drive at a negedge, drop at the next negedge (outputs now reflect it).
  task automatic issue(input logic [3:0] o, input logic [19:0] opd,
                       input logic [19:0] res, input logic z, input logic c);
    @(negedge clk);
    in_valid = 1'b1; op = o; operand = opd; alu_result = res; alu_zero = z; alu_carry = c;
    @(negedge clk);
    in_valid = 1'b0;
    if (o < 4'd8) exp_ret = exp_ret + 16'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (status !== 3'b000) $display("FAIL reset_status got %b exp 000", status); else pass_cnt++;
    total++; if ({br_valid, br_taken, trap, trap_cause} !== 4'b0000)
      $display("FAIL reset_flags got %b exp 0000", {br_valid, br_taken, trap, trap_cause}); else pass_cnt++;
    total++; if (br_target !== 20'h0) $display("FAIL reset_target got %h exp 00000", br_target); else pass_cnt++;
    total++; if (retired !== 16'h0) $display("FAIL reset_retired got %h exp 0000", retired); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_flags();
    issue(4'd1, 20'h0, 20'h80000, 1'b0, 1'b1);
    total++; if (status !== 3'b110) $display("FAIL flags_status got %b exp 110", status); else pass_cnt++;
    total++; if (retired !== 16'd1) $display("FAIL flags_retired got %0d exp 1", retired); else pass_cnt++;
    total++; if (br_valid !== 1'b0) $display("FAIL flags_brvalid got %b exp 0", br_valid); else pass_cnt++;
  endtask

  task automatic test_jumps();
    issue(4'd1, 20'h0, 20'h00000, 1'b1, 1'b0);
    total++; if (status !== 3'b001) $display("FAIL jz_pre_status got %b exp 001", status); else pass_cnt++;
    issue(4'd3, 20'h00123, 20'h0, 1'b0, 1'b0);
    total++; if ({br_valid, br_taken} !== 2'b11) $display("FAIL jz_branch got %b exp 11", {br_valid, br_taken}); else pass_cnt++;
    total++; if (br_target !== 20'h00123) $display("FAIL jz_target got %h exp 00123", br_target); else pass_cnt++;
    @(negedge clk);
    total++; if (br_valid !== 1'b0) $display("FAIL jz_pulse got %b exp 0", br_valid); else pass_cnt++;
    total++; if ({br_taken, br_target} !== {1'b1, 20'h00123})
      $display("FAIL jz_hold got %b/%h exp 1/00123", br_taken, br_target); else pass_cnt++;
    issue(4'd4, 20'h00456, 20'h0, 1'b0, 1'b0);
    total++; if ({br_valid, br_taken} !== 2'b10) $display("FAIL js_branch got %b exp 10", {br_valid, br_taken}); else pass_cnt++;
    total++; if (br_target !== 20'h00456) $display("FAIL js_target got %h exp 00456", br_target); else pass_cnt++;
    issue(4'd2, 20'hABCDE, 20'h0, 1'b0, 1'b0);
    total++; if ({br_valid, br_taken, br_target} !== {2'b11, 20'hABCDE})
      $display("FAIL jmp_branch got %b%b/%h exp 11/abcde", br_valid, br_taken, br_target); else pass_cnt++;
  endtask

  task automatic test_status_ops();
    issue(4'd6, 20'h00005, 20'h0, 1'b0, 1'b0);
    total++; if (status !== 3'b101) $display("FAIL lsr_status got %b exp 101", status); else pass_cnt++;
    issue(4'd7, 20'h00003, 20'h0, 1'b0, 1'b0);
    total++; if (status !== 3'b110) $display("FAIL xsr_status got %b exp 110", status); else pass_cnt++;
    issue(4'd5, 20'h00777, 20'h0, 1'b0, 1'b0);
    total++; if ({br_valid, br_taken} !== 2'b11) $display("FAIL jzs_branch got %b exp 11", {br_valid, br_taken}); else pass_cnt++;
    total++; if (retired !== exp_ret) $display("FAIL ops_retired got %0d exp %0d", retired, exp_ret); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // FLAGS sets Z=1 (status was 110, Z=0); JZ in the very next cycle must see Z=1.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd1; alu_result = 20'h00000; alu_zero = 1'b1; alu_carry = 1'b0;
    @(negedge clk);
    op = 4'd3; operand = 20'h00AAA;
    @(negedge clk);
    in_valid = 1'b0;
    exp_ret = exp_ret + 16'd2;
    total++; if ({br_valid, br_taken, br_target} !== {2'b11, 20'h00AAA})
      $display("FAIL b2b_branch got %b%b/%h exp 11/00aaa", br_valid, br_taken, br_target); else pass_cnt++;
    total++; if (status !== 3'b001) $display("FAIL b2b_status got %b exp 001", status); else pass_cnt++;
    total++; if (retired !== exp_ret) $display("FAIL b2b_retired got %0d exp %0d", retired, exp_ret); else pass_cnt++;
  endtask

  task automatic test_trap();
    // trap_clr while running has no effect.
    @(negedge clk); trap_clr = 1'b1;
    @(negedge clk); trap_clr = 1'b0;
    total++; if ({trap, in_ready} !== 2'b01) $display("FAIL clr_in_run got %b exp 01", {trap, in_ready}); else pass_cnt++;
    issue(4'd8, 20'h0, 20'h0, 1'b0, 1'b0);
    total++; if ({trap, trap_cause, in_ready} !== 3'b100)
      $display("FAIL trap_entry got %b exp 100", {trap, trap_cause, in_ready}); else pass_cnt++;
    total++; if (retired !== exp_ret) $display("FAIL trap_retired got %0d exp %0d", retired, exp_ret); else pass_cnt++;
    // Held NOP must not be taken while trapped.
    in_valid = 1'b1; op = 4'd0;
    repeat (3) @(negedge clk);
    total++; if ({retired, trap} !== {exp_ret, 1'b1})
      $display("FAIL trap_hold got %0d/%b exp %0d/1", retired, trap, exp_ret); else pass_cnt++;
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    total++; if ({trap, in_ready} !== 2'b01) $display("FAIL trap_exit got %b exp 01", {trap, in_ready}); else pass_cnt++;
    total++; if (retired !== exp_ret) $display("FAIL trap_exit_retired got %0d exp %0d", retired, exp_ret); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    exp_ret = exp_ret + 16'd1;
    total++; if (retired !== exp_ret) $display("FAIL nop_after_trap got %0d exp %0d", retired, exp_ret); else pass_cnt++;
    total++; if ({status, br_target, trap_cause} !== {3'b001, 20'h00AAA, 1'b0})
      $display("FAIL trap_preserve got %b/%h/%b exp 001/00aaa/0", status, br_target, trap_cause); else pass_cnt++;
  endtask

  task automatic test_illegal();
    issue(4'hB, 20'h0, 20'h0, 1'b0, 1'b0);
    total++; if ({trap, trap_cause, in_ready} !== 3'b110)
      $display("FAIL illegal_entry got %b exp 110", {trap, trap_cause, in_ready}); else pass_cnt++;
    total++; if (retired !== exp_ret) $display("FAIL illegal_retired got %0d exp %0d", retired, exp_ret); else pass_cnt++;
    // Assert reset between clock edges; outputs must clear without an edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({trap, trap_cause, in_ready, status} !== 6'b001000)
      $display("FAIL async_reset got %b exp 001000", {trap, trap_cause, in_ready, status}); else pass_cnt++;
    total++; if (retired !== 16'h0) $display("FAIL async_reset_retired got %0d exp 0", retired); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0;
    repeat (65535) @(negedge clk);
    in_valid = 1'b0;
    total++; if (retired !== 16'hFFFF) $display("FAIL wrap_preset got %h exp ffff", retired); else pass_cnt++;
    issue(4'd0, 20'h0, 20'h0, 1'b0, 1'b0);
    total++; if (retired !== 16'h0000) $display("FAIL wrap_zero got %h exp 0000", retired); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; alu_result = '0; alu_zero = 1'b0;
    alu_carry = 1'b0; operand = '0; trap_clr = 1'b0;
    test_reset();
    test_flags();
    test_jumps();
    test_status_ops();
    test_back_to_back();
    test_trap();
    test_illegal();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
